// File: rtl/string_pkg.sv
// Shared definitions for the 8-character null-terminated string format:
// 64-bit word, char 0 in the top byte, unused bytes 0x00.
package string_pkg;

  localparam int CHAR_W    = 8;
  localparam int MAX_CHARS = 8;
  localparam int STR_W     = MAX_CHARS * CHAR_W;
  localparam int LEN_W     = 4;

  localparam logic [CHAR_W-1:0] NUL = 8'h00;

  typedef enum logic {
    COLLECT = 1'b0,
    DONE    = 1'b1
  } state_t;

endpackage

// File: rtl/string_builder.sv
// Packs incoming characters MSB-first into a null-terminated string word and
// hands the finished string, with its length, to a valid/ready consumer.
module string_builder #(
  parameter int MAX_CHARS = 8,
  parameter int CHAR_W    = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [CHAR_W-1:0]           char_in,
  input  logic                        char_valid,
  output logic                        char_ready,
  input  logic                        clear,
  output logic [MAX_CHARS*CHAR_W-1:0] str_out,
  output logic [3:0]                  str_len,
  output logic                        str_valid,
  input  logic                        str_ready
);
  import string_pkg::*;

  state_t                        state;
  state_t                        state_next;
  logic                          run;
  logic [3:0]                    count;
  logic [MAX_CHARS*CHAR_W-1:0]   buffer;
  logic                          accept;
  logic                          is_nul;
  logic                          last;

  // run holds char_ready low through reset and releases it one edge later
  assign char_ready = run & (state == COLLECT) & ~clear;
  assign str_valid  = (state == DONE);
  assign str_out    = buffer;
  assign accept     = char_valid & char_ready;
  assign is_nul     = (char_in == '0);
  assign last       = (count == 4'(MAX_CHARS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= COLLECT;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = COLLECT;
    end else begin
      case (state)
        COLLECT: if (accept && (is_nul || last)) state_next = DONE;
        DONE:    if (str_ready) state_next = COLLECT;
        default: state_next = COLLECT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run    <= 1'b0;
      buffer <= '0;
      count  <= '0;
      str_len <= '0;
    end else begin
      run <= 1'b1;
      if (clear || (state == DONE && str_ready)) begin
        buffer  <= '0;
        count   <= '0;
        str_len <= '0;
      end else if (accept) begin
        if (is_nul) begin
          str_len <= count;
        end else begin
          // Unwritten slots stay 0x00, so length always equals first-NUL index
          for (int i = 0; i < MAX_CHARS; i++) begin
            if (count == 4'(i)) buffer[(MAX_CHARS-1-i)*CHAR_W +: CHAR_W] <= char_in;
          end
          count <= count + 4'd1;
          if (last) str_len <= 4'(MAX_CHARS);
        end
      end
    end
  end

endmodule

// File: tb/tb_string_builder.sv
// Scoreboard bench for string_builder: stimulus pushes expected strings,
// a negedge monitor pops and compares on every str_valid & str_ready.
module tb_string_builder;
  import string_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [CHAR_W-1:0] char_in = '0;
  logic              char_valid = 1'b0;
  logic              char_ready;
  logic              clear = 1'b0;
  logic [STR_W-1:0]  str_out;
  logic [3:0]        str_len;
  logic              str_valid;
  logic              str_ready = 1'b1;

  typedef struct packed {
    logic [STR_W-1:0] s;
    logic [LEN_W-1:0] l;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          total = 0;
  int          passed = 0;
  int          pushed = 0;
  int          popped = 0;
  bit          rand_gaps = 1'b0;
  logic [7:0]  rbuf [MAX_CHARS];

  string_builder #(.MAX_CHARS(MAX_CHARS), .CHAR_W(CHAR_W)) dut (
    .clk(clk), .rst_n(rst_n), .char_in(char_in), .char_valid(char_valid),
    .char_ready(char_ready), .clear(clear), .str_out(str_out),
    .str_len(str_len), .str_valid(str_valid), .str_ready(str_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endtask

  function automatic int ref_len(input logic [STR_W-1:0] s);
    for (int i = 0; i < MAX_CHARS; i++)
      if (s[STR_W-1-CHAR_W*i -: CHAR_W] == NUL) return i;
    return MAX_CHARS;
  endfunction

  always @(negedge clk) begin
    if (rst_n && str_valid && str_ready) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL unexpected_string: got %h len %0d, required none", str_out, str_len);
      end else begin
        mon_e = sb.pop_front();
        popped++;
        check("str_out", str_out, mon_e.s);
        check("str_len", 64'(str_len), 64'(mon_e.l));
        check("ref_len", 64'(str_len), 64'(ref_len(str_out)));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_gaps) str_ready = ($urandom_range(0, 2) != 0);
  endtask

  task automatic expect_str(input logic [STR_W-1:0] s, input int l);
    exp_t e;
    e.s = s;
    e.l = LEN_W'(l);
    sb.push_back(e);
    pushed++;
  endtask

  task automatic send(input logic [7:0] c);
    int n;
    if (rand_gaps) repeat ($urandom_range(0, 2)) tick();
    char_in = c;
    char_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!char_ready && n < 1000) begin
      tick();
      @(negedge clk);
      n++;
    end
    if (!char_ready) begin
      total++;
      $display("FAIL send_timeout: char_ready 0, required 1");
    end
    tick();
    char_valid = 1'b0;
  endtask

  task automatic send_random();
    int n;
    logic [STR_W-1:0] s;
    n = $urandom_range(0, MAX_CHARS);
    s = '0;
    for (int i = 0; i < n; i++) begin
      rbuf[i] = 8'($urandom_range(1, 255));
      s[STR_W-1-CHAR_W*i -: CHAR_W] = rbuf[i];
    end
    expect_str(s, n);
    for (int i = 0; i < n; i++) send(rbuf[i]);
    if (n < MAX_CHARS) send(NUL);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    #2;
    check("rst_char_ready", 64'(char_ready), 64'd0);
    check("rst_str_valid", 64'(str_valid), 64'd0);
    check("rst_str_out", str_out, 64'd0);
    check("rst_str_len", 64'(str_len), 64'd0);
    #20 rst_n = 1'b1;
    tick();
    check("post_rst_char_ready", 64'(char_ready), 64'd1);

    // AA BB CC terminator
    expect_str(64'hAABBCC0000000000, 3);
    send(8'hAA); send(8'hBB); send(8'hCC); send(8'h00);
    @(negedge clk);
    check("t1_valid_high", 64'(str_valid), 64'd1);
    tick();
    @(negedge clk);
    check("t1_valid_one_cycle", 64'(str_valid), 64'd0);
    check("t1_char_ready_back", 64'(char_ready), 64'd1);
    tick();

    // full string then a lone terminator
    expect_str(64'h1122334455667788, 8);
    expect_str(64'h0, 0);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    send(8'h55); send(8'h66); send(8'h77); send(8'h88);
    @(negedge clk);
    check("t2_valid_after_8th", 64'(str_valid), 64'd1);
    tick();
    send(8'h00);
    tick(); tick();

    // empty string held with str_ready low
    str_ready = 1'b0;
    expect_str(64'h0, 0);
    send(8'h00);
    for (int k = 0; k < 4; k++) begin
      char_valid = (k % 2 == 0);
      char_in = 8'h55;
      @(negedge clk);
      check("t3_hold_valid", 64'(str_valid), 64'd1);
      check("t3_hold_out", str_out, 64'd0);
      check("t3_hold_len", 64'(str_len), 64'd0);
      check("t3_hold_char_ready", 64'(char_ready), 64'd0);
      tick();
    end
    char_valid = 1'b0;
    str_ready = 1'b1;
    tick(); tick();

    // clear drops partial string and the concurrent character
    expect_str(64'h4100000000000000, 1);
    send(8'hDE); send(8'hAD);
    clear = 1'b1; char_valid = 1'b1; char_in = 8'hBE;
    @(negedge clk);
    check("t4_clear_char_ready", 64'(char_ready), 64'd0);
    tick();
    clear = 1'b0; char_valid = 1'b0;
    send(8'h41); send(8'h00);
    tick();

    // reset mid-string
    send(8'h01); send(8'h02); send(8'h03); send(8'h04); send(8'h05);
    @(negedge clk);
    check("t5_partial_visible", str_out, 64'h0102030405000000);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_out", str_out, 64'd0);
    check("t5_rst_len", 64'(str_len), 64'd0);
    check("t5_rst_valid", 64'(str_valid), 64'd0);
    check("t5_rst_char_ready", 64'(char_ready), 64'd0);
    #3 rst_n = 1'b1;
    tick();
    check("t5_char_ready_after", 64'(char_ready), 64'd1);
    expect_str(64'h0A0B000000000000, 2);
    send(8'h0A); send(8'h0B); send(8'h00);
    tick();

    // reset while a string waits in DONE
    str_ready = 1'b0;
    send(8'h12); send(8'h00);
    @(negedge clk);
    check("t6_done_valid", 64'(str_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_out", str_out, 64'd0);
    check("t6_rst_len", 64'(str_len), 64'd0);
    check("t6_rst_valid", 64'(str_valid), 64'd0);
    #3 rst_n = 1'b1;
    str_ready = 1'b1;
    tick();
    expect_str(64'h7700000000000000, 1);
    send(8'h77); send(8'h00);
    tick();

    // random gaps on both handshakes
    rand_gaps = 1'b1;
    for (int k = 0; k < 500; k++) send_random();
    rand_gaps = 1'b0;
    str_ready = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    tick();
    check("sb_drained", 64'(sb.size()), 64'd0);
    check("strings_seen", 64'(popped), 64'(pushed));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/string_builder.md
Name: string_builder

Overview:
Writer side of the 8-character null-terminated string format: 64-bit word, char 0 in bits [63:56], unused bytes 0x00, length 0..8.
- Accepts characters one per valid/ready handshake.
- Packs them MSB-first and ends the string on a 0x00 terminator or the 8th character.
- Presents the packed string plus its length on a valid/ready output port.
- Sits between a character source (keyboard/UART front end) and string consumers.

Parameters:
MAX_CHARS, 8, string capacity in characters; output word is MAX_CHARS*CHAR_W bits.
CHAR_W, 8, bits per character.

Ports:
clk  in  1  system clock, all state on rising edge.
rst_n  in  1  asynchronous active-low reset.
char_in  in  CHAR_W  incoming character; 0x00 is the terminator.
char_valid  in  1  char_in valid.
char_ready  out  1  builder can accept a character.
clear  in  1  synchronous abort; discards the partial string.
str_out  out  MAX_CHARS*CHAR_W  packed string, char 0 in the top byte.
str_len  out  4  number of non-null characters, 0..8.
str_valid  out  1  str_out/str_len hold a completed string.
str_ready  in  1  consumer accepts the string.

Behaviour:
- Reset (rst_n low, asynchronous):
  - buffer=0, count=0, state=COLLECT.
  - str_out=0, str_len=0, str_valid=0.
  - char_ready=0 while rst_n is low; char_ready=1 from the first cycle after release.
- States: COLLECT and DONE. char_ready = (state==COLLECT) & ~clear. str_valid = (state==DONE). Both are decoded from registered state; there is no combinational path from the inputs except clear.
- COLLECT, accept when char_valid & char_ready:
  - char_in==0x00: terminator is not stored; str_len=count; state->DONE.
  - Otherwise: byte slot [63-8*count -: 8] = char_in; count+1. If the new count==MAX_CHARS, str_len=8 and state->DONE.
- DONE:
  - str_out, str_len and str_valid are held stable while str_ready=0. char_ready=0.
  - On str_ready=1: buffer cleared to 0, count=0, state->COLLECT. char_ready=1 on the next cycle.
- Latency: str_valid rises the cycle after the terminating handshake. Minimum string period is (chars accepted + 1 terminator if any) + 1 DONE cycle.
- Empty string: a terminator as the first character gives str_out=0, str_len=0, str_valid=1.
- Full string: the 8th non-null character ends the string with no terminator consumed. A following 0x00 on char_in is treated as the first character of the next string (an empty string).
- Unfilled bytes are always 0x00. The output therefore always satisfies: length = index of the first 0x00 byte, or 8 if none.
- char_valid with a non-null char while in DONE: not accepted, no effect.
- clear has highest priority below reset, in either state:
  - buffer=0, count=0, state->COLLECT, str_valid=0 next cycle.
  - A character presented in the same cycle is dropped (char_ready is already 0).
- clear and str_ready both high in DONE: same result as clear.
- count is 4 bits and saturates by construction; it is never incremented past MAX_CHARS.
- Reset mid-string or mid-DONE: immediate return to reset values; a pending string is lost.

Decomposition:
- Shared package, string_pkg:
  - CHAR_W, MAX_CHARS, STR_W = MAX_CHARS*CHAR_W, LEN_W = 4.
  - NUL = 8'h00.
  - State encoding (COLLECT=0, DONE=1).
- Sub-modules: none. Byte-slot write, counter and 2-state FSM stay in one module, about 150 lines.
- The bench reuses string_pkg and includes a reference length function: index of the first NUL, MSB-first, else 8.

Test Plan:
- Feed AA,BB,CC,00 with str_ready=1 -> str_out=64'hAABBCC0000000000, str_len=3, str_valid high for exactly 1 cycle, char_ready back to 1 the next cycle.
- Feed 11,22,33,44,55,66,77,88 (no terminator) -> str_out=64'h1122334455667788, str_len=8 on the cycle after the 8th handshake; a following 00 yields str_out=0, str_len=0.
- First char 00 -> str_out=0, str_len=0, str_valid=1; hold str_ready=0 for 4 cycles -> outputs stable, char_ready=0, char_valid pulses ignored.
- Feed DE,AD then clear=1 with char_valid=1 and char_in=BE -> BE dropped; then feed 41,00 -> str_out=64'h4100000000000000, str_len=1.
- Random gaps on char_valid and str_ready, 500 random strings -> str_len equals the reference length of str_out on every str_valid & str_ready; no character lost or duplicated.
- Assert rst_n low mid-string (after 5 chars) and again during DONE -> str_valid, str_out and str_len drop to 0 asynchronously; the next string builds from slot 0.
